score_display: RTL

SCORE_DISPLAY -- requirements
Module: score_display

---
 rtl/score_display.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/score_display.sv
// -----------------------------------------------------------------------------
// score_display
//   Converts a 32-bit binary score to four BCD digits with a sequential
//   double-dabble engine (IDLE -> SHIFT x32 -> COMMIT) and drives a
//   multiplexed, active-low 4-digit seven-segment display. Scores above 9999
//   saturate to 9999 and raise overflow.
//
// Configuration macro:
//   SCORE_BLANK_EN - when defined, leading-zero digits (position > 0) are
//                    blanked by holding their anode high.
//
// Parameters:
//   REFRESH_DIV - clk cycles each digit is driven before moving to the next
//                 digit (legal 2..2^20).
//
// Ports:
//   clk      in   sole clock, rising edge
//   reset    in   synchronous active-high reset
//   score    in   [31:0] unsigned score, sampled only in IDLE
//   seg      out  [6:0] active-low cathodes {g,f,e,d,c,b,a}
//   an       out  [3:0] active-low anodes, an[0] = ones digit
//   dp       out  active-low decimal point, always off (1)
//   busy     out  high during SHIFT and COMMIT
//   overflow out  high while the committed value was saturated
// -----------------------------------------------------------------------------
module score_display #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] score,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic        dp,
  output logic        busy,
  output logic        overflow
);

  localparam int            CW      = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] DIV_MAX = CW'(REFRESH_DIV - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

  state_t        state_q, state_d;
  logic [31:0]   last_score_q, last_score_d;
  logic [31:0]   shift_q, shift_d;
  logic [15:0]   bcd_q, bcd_d;
  logic [15:0]   digits_q, digits_d;
  logic [4:0]    bit_cnt_q, bit_cnt_d;
  logic          sat_q, sat_d;
  logic          ovf_q, ovf_d;
  logic [CW-1:0] refresh_q, refresh_d;
  logic [1:0]    sel_q, sel_d;
  logic [6:0]    seg_q, seg_d;
  logic [3:0]    an_q, an_d;

  logic [15:0]   bcd_adj;
  logic [3:0]    blank;
  logic [3:0]    digit_cur;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = 7'b1000000;
      4'd1:    seg_decode = 7'b1111001;
      4'd2:    seg_decode = 7'b0100100;
      4'd3:    seg_decode = 7'b0110000;
      4'd4:    seg_decode = 7'b0011001;
      4'd5:    seg_decode = 7'b0010010;
      4'd6:    seg_decode = 7'b0000010;
      4'd7:    seg_decode = 7'b1111000;
      4'd8:    seg_decode = 7'b0000000;
      4'd9:    seg_decode = 7'b0010000;
      default: seg_decode = 7'b1111111;
    endcase
  endfunction

  // Double-dabble correction: any nibble >= 5 gets +3 before the shift so it
  // carries correctly into the next decade.
  for (genvar gi = 0; gi < 4; gi++) begin : g_adj
    assign bcd_adj[gi*4 +: 4] = (bcd_q[gi*4 +: 4] >= 4'd5) ?
                                (bcd_q[gi*4 +: 4] + 4'd3) : bcd_q[gi*4 +: 4];
  end

`ifdef SCORE_BLANK_EN
  // A digit is blank when it and every digit above it are zero; the ones
  // digit is never blanked so a zero score still shows "0".
  assign blank[3] = (digits_d[15:12] == 4'd0);
  assign blank[2] = blank[3] && (digits_d[11:8] == 4'd0);
  assign blank[1] = blank[2] && (digits_d[7:4] == 4'd0);
  assign blank[0] = 1'b0;
`else
  assign blank = 4'b0000;
`endif

  // Conversion FSM
  always_comb begin
    state_d      = state_q;
    last_score_d = last_score_q;
    shift_d      = shift_q;
    bcd_d        = bcd_q;
    digits_d     = digits_q;
    bit_cnt_d    = bit_cnt_q;
    sat_d        = sat_q;
    ovf_d        = ovf_q;
    case (state_q)
      IDLE: begin
        if (score != last_score_q) begin
          shift_d      = (score > 32'd9999) ? 32'd9999 : score;
          last_score_d = score;
          sat_d        = (score > 32'd9999);
          bcd_d        = 16'd0;
          bit_cnt_d    = 5'd0;
          state_d      = SHIFT;
        end
      end
      SHIFT: begin
        {bcd_d, shift_d} = {bcd_adj, shift_q} << 1;
        bit_cnt_d        = bit_cnt_q + 5'd1;
        if (bit_cnt_q == 5'd31) begin
          state_d = COMMIT;
        end
      end
      COMMIT: begin
        digits_d = bcd_q;
        ovf_d    = sat_q;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Display scan. seg/an are computed from the next-state digit and select so
  // the registered outputs always match the digit registers after each edge.
  always_comb begin
    refresh_d = refresh_q + CW'(1);
    sel_d     = sel_q;
    if (refresh_q == DIV_MAX) begin
      refresh_d = '0;
      sel_d     = sel_q + 2'd1;
    end
    digit_cur = digits_d[{sel_d, 2'b00} +: 4];
    seg_d     = seg_decode(digit_cur);
    an_d      = ~((4'b0001 << sel_d) & ~blank);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_score_q <= '0;
      shift_q      <= '0;
      bcd_q        <= '0;
      digits_q     <= '0;
      bit_cnt_q    <= '0;
      sat_q        <= 1'b0;
      ovf_q        <= 1'b0;
      refresh_q    <= '0;
      sel_q        <= '0;
      seg_q        <= 7'b1000000;
      an_q         <= 4'b1110;
    end else begin
      state_q      <= state_d;
      last_score_q <= last_score_d;
      shift_q      <= shift_d;
      bcd_q        <= bcd_d;
      digits_q     <= digits_d;
      bit_cnt_q    <= bit_cnt_d;
      sat_q        <= sat_d;
      ovf_q        <= ovf_d;
      refresh_q    <= refresh_d;
      sel_q        <= sel_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
    end
  end

  assign seg      = seg_q;
  assign an       = an_q;
  assign dp       = 1'b1;
  assign busy     = (state_q != IDLE);
  assign overflow = ovf_q;

endmodule
